// File: rtl/motion_sequencer.sv
// Waypoint scheduler: queues target positions with dwell times, drives the position
// controller, supervises each move with a timeout. Optional MOTION_SEQ_LOOP_EN adds loop_mode.
module motion_sequencer #(
  parameter int clk_freq_hz     = 27_000_000,
  parameter int counter_width   = 32,
  parameter int depth           = 4,
  parameter int dwell_width     = 16,
  parameter int move_timeout_ms = 2000
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         wp_valid,
  output logic                         wp_ready,
  input  logic [counter_width-1:0]     wp_position,
  input  logic [dwell_width-1:0]       wp_dwell_ms,
  input  logic                         start,
  input  logic                         abort,
  input  logic [counter_width-1:0]     encoder_position,
  output logic                         pc_enable,
  output logic [counter_width-1:0]     pc_target,
  output logic                         busy,
  output logic                         done,
  output logic                         fault,
  output logic [$clog2(depth+1)-1:0]   queue_count,
`ifdef MOTION_SEQ_LOOP_EN
  input  logic                         loop_mode,
`endif
  output logic [1:0]                   dbg_state
);

  localparam int TICK = clk_freq_hz / 1000;
  localparam int PW   = (TICK > 1) ? $clog2(TICK) : 1;
  localparam int TW   = $clog2(move_timeout_ms + 1);
  localparam int MW   = (dwell_width > TW) ? dwell_width : TW;
  localparam int AW   = $clog2(depth);
  localparam int CW   = $clog2(depth + 1);
  localparam int EW   = counter_width + dwell_width;

  typedef enum logic [1:0] {IDLE = 2'd0, MOVE = 2'd1, DWELL = 2'd2, FAULT = 2'd3} state_t;

  state_t                   state;
  logic [EW-1:0]            mem [depth];
  logic [AW-1:0]            rd_ptr, wr_ptr;
  logic [CW-1:0]            count;
  logic [PW-1:0]            presc;
  logic [MW-1:0]            ms_cnt, ms_next;
  logic [dwell_width-1:0]   dwell_reg;
  logic [EW-1:0]            head;
  logic                     ms_tick, arrive, timeout_hit, dwell_exit;
  logic                     pop, repush, push_ok, loop_on;

`ifdef MOTION_SEQ_LOOP_EN
  assign loop_on  = loop_mode;
  assign wp_ready = (count < CW'(depth)) & ~busy;
`else
  assign loop_on  = 1'b0;
  assign wp_ready = count < CW'(depth);
`endif

  assign queue_count = count;
  assign dbg_state   = state;
  assign head        = mem[rd_ptr];

  always_comb begin
    ms_tick     = (presc == PW'(TICK - 1));
    ms_next     = ms_cnt + MW'(1);
    arrive      = (encoder_position == pc_target);
    timeout_hit = ms_tick && (ms_next == MW'(move_timeout_ms));
    // A zero dwell leaves after the single entry cycle; otherwise leave on the tick
    // that would make the ms counter equal the dwell.
    dwell_exit  = (dwell_reg == '0) || (ms_tick && (ms_next == MW'(dwell_reg)));
    pop         = !abort && (count != '0) &&
                  (((state == IDLE) && start) || ((state == DWELL) && dwell_exit));
    repush      = pop & loop_on;
    push_ok     = wp_valid & wp_ready & ~abort & ~repush;
  end

  // Queue storage needs no reset: validity is tracked entirely by count.
  always_ff @(posedge sys_clk) begin
    if (push_ok)     mem[wr_ptr] <= {wp_position, wp_dwell_ms};
    else if (repush) mem[wr_ptr] <= head;
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok || repush) wr_ptr <= wr_ptr + AW'(1);
      if (pop)               rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= repush ? count : count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pc_enable <= 1'b0;
      pc_target <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      dwell_reg <= '0;
      presc     <= '0;
      ms_cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (ms_tick) begin
        presc  <= '0;
        ms_cnt <= ms_next;
      end else begin
        presc  <= presc + PW'(1);
      end
      if (abort) begin
        state     <= IDLE;
        pc_enable <= 1'b0;
        busy      <= 1'b0;
        fault     <= 1'b0;
        presc     <= '0;
        ms_cnt    <= '0;
      end else begin
        case (state)
          IDLE: if (pop) begin
            state     <= MOVE;
            pc_target <= head[EW-1:dwell_width];
            dwell_reg <= head[dwell_width-1:0];
            pc_enable <= 1'b1;
            busy      <= 1'b1;
            presc     <= '0;
            ms_cnt    <= '0;
          end
          MOVE: if (arrive) begin
            state  <= DWELL;
            presc  <= '0;
            ms_cnt <= '0;
          end else if (timeout_hit) begin
            state     <= FAULT;
            fault     <= 1'b1;
            pc_enable <= 1'b0;
            busy      <= 1'b0;
            presc     <= '0;
            ms_cnt    <= '0;
          end
          DWELL: if (dwell_exit) begin
            presc  <= '0;
            ms_cnt <= '0;
            if (pop) begin
              state     <= MOVE;
              pc_target <= head[EW-1:dwell_width];
              dwell_reg <= head[dwell_width-1:0];
            end else begin
              state     <= IDLE;
              pc_enable <= 1'b0;
              busy      <= 1'b0;
              done      <= ~loop_on;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Directed bench for motion_sequencer at 10 cycles/ms with a 5 ms move timeout;
// pushed targets go to a scoreboard that is checked on every entry into MOVE.
module tb_motion_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0, S_MOVE = 2'd1, S_DWELL = 2'd2, S_FAULT = 2'd3;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wp_valid = 1'b0;
  logic        wp_ready;
  logic [31:0] wp_position = '0;
  logic [15:0] wp_dwell_ms = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] encoder_position = '0;
  logic        pc_enable;
  logic [31:0] pc_target;
  logic        busy, done, fault;
  logic [2:0]  queue_count;
  logic [1:0]  dbg_state;

  logic [31:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [1:0] prev_state = S_IDLE;

  motion_sequencer #(
    .clk_freq_hz(10_000), .counter_width(32), .depth(4),
    .dwell_width(16), .move_timeout_ms(5)
  ) dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .wp_valid(wp_valid), .wp_ready(wp_ready),
    .wp_position(wp_position), .wp_dwell_ms(wp_dwell_ms), .start(start), .abort(abort),
    .encoder_position(encoder_position), .pc_enable(pc_enable), .pc_target(pc_target),
    .busy(busy), .done(done), .fault(fault), .queue_count(queue_count),
    .dbg_state(dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every entry into MOVE must present the oldest outstanding target.
  always @(negedge sys_clk) begin
    if (done === 1'b1) done_cnt++;
    if (dbg_state === S_MOVE && prev_state !== S_MOVE) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_empty observed=%0h expected=none", pc_target);
      end else begin
        check("sb_target", pc_target, exp_q.pop_front());
      end
    end
    prev_state = dbg_state;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [15:0] d, input bit accept);
    wp_position = p;
    wp_dwell_ms = d;
    wp_valid    = 1'b1;
    tick();
    wp_valid    = 1'b0;
    if (accept) exp_q.push_back(p);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n = 0;
    while (dbg_state !== s && n < 500) begin
      tick();
      n++;
    end
    check(tag, dbg_state, s);
  endtask

  task automatic serve_move(input logic [31:0] p);
    wait_state(S_MOVE, "serve_move");
    repeat (2) tick();
    encoder_position = p;
    wait_state(S_DWELL, "serve_dwell");
  endtask

  initial begin
    int cyc;
    int dc0;

    // Reset values
    #2;
    check("rst_ready", wp_ready, 1);
    check("rst_count", queue_count, 0);
    check("rst_en", pc_enable, 0);
    check("rst_target", pc_target, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fault", fault, 0);
    #20 reset_n = 1'b1;
    tick();

    // Single move, 2 ms dwell
    push(32'd100, 16'd2, 1);
    check("single_count", queue_count, 1);
    dc0 = done_cnt;
    pulse_start();
    check("single_en", pc_enable, 1);
    check("single_target", pc_target, 100);
    check("single_busy", busy, 1);
    repeat (6) tick();
    encoder_position = 32'd100;
    tick();
    check("single_dwell_entry", dbg_state, S_DWELL);
    cyc = 1;
    while (dbg_state === S_DWELL && cyc < 500) begin
      tick();
      if (dbg_state === S_DWELL) cyc++;
    end
    check("single_dwell_len", cyc, 20);
    check("single_done", done, 1);
    check("single_en_off", pc_enable, 0);
    check("single_count_end", queue_count, 0);
    tick();
    check("single_done_pulse", done, 0);
    check("single_done_cnt", done_cnt - dc0, 1);

    // Full queue, overflow push ignored, run in order
    push(32'd10, 16'd0, 1);
    push(32'd20, 16'd1, 1);
    push(32'd30, 16'd0, 1);
    push(32'd40, 16'd0, 1);
    check("full_ready", wp_ready, 0);
    check("full_count", queue_count, 4);
    push(32'd50, 16'd0, 0);
    check("full_count_ovf", queue_count, 4);
    dc0 = done_cnt;
    pulse_start();
    serve_move(32'd10);
    serve_move(32'd20);
    serve_move(32'd30);
    serve_move(32'd40);
    cyc = 0;
    while (done_cnt == dc0 && cyc < 200) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    check("full_done_cnt", done_cnt - dc0, 1);
    check("full_sb_drained", exp_q.size(), 0);
    check("full_count_end", queue_count, 0);

    // Move timeout with one entry left queued
    encoder_position = 32'd0;
    push(32'd500, 16'd0, 1);
    push(32'd600, 16'd0, 1);
    pulse_start();
    check("to_en", pc_enable, 1);
    cyc = 0;
    while (fault !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("to_cycles", cyc, 50);
    check("to_fault", fault, 1);
    check("to_en_off", pc_enable, 0);
    check("to_busy", busy, 0);
    check("to_retained", queue_count, 1);
    pulse_start();
    tick();
    check("to_start_ignored", dbg_state, S_FAULT);
    check("to_fault_hold", fault, 1);
    abort = 1'b1;
    wp_valid = 1'b1;
    wp_position = 32'd777;
    tick();
    abort = 1'b0;
    wp_valid = 1'b0;
    exp_q.delete();
    check("to_abort_fault", fault, 0);
    check("to_abort_count", queue_count, 0);
    check("to_abort_state", dbg_state, S_IDLE);

    // Abort in DWELL with two entries behind it
    push(32'd200, 16'd5, 1);
    push(32'd300, 16'd0, 1);
    push(32'd400, 16'd0, 1);
    dc0 = done_cnt;
    pulse_start();
    serve_move(32'd200);
    repeat (5) tick();
    check("ab_in_dwell", dbg_state, S_DWELL);
    check("ab_count", queue_count, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("ab_state", dbg_state, S_IDLE);
    check("ab_en", pc_enable, 0);
    check("ab_count_flush", queue_count, 0);
    check("ab_done", done, 0);
    repeat (3) tick();
    check("ab_no_done", done_cnt - dc0, 0);

    // Wrap-around targets with zero dwell
    push(32'hFFFF_FFFF, 16'd0, 1);
    push(32'h0000_0002, 16'd0, 1);
    pulse_start();
    repeat (2) tick();
    encoder_position = 32'hFFFF_FFFF;
    tick();
    check("wrap_dwell1", dbg_state, S_DWELL);
    tick();
    check("wrap_dwell1_len", dbg_state, S_MOVE);
    check("wrap_target2", pc_target, 32'h2);
    tick();
    encoder_position = 32'h0000_0002;
    tick();
    check("wrap_dwell2", dbg_state, S_DWELL);
    tick();
    check("wrap_idle", dbg_state, S_IDLE);
    check("wrap_done", done, 1);

    // Asynchronous reset while moving
    encoder_position = 32'd0;
    push(32'd700, 16'd0, 1);
    push(32'd800, 16'd0, 1);
    pulse_start();
    check("rst_mv_en", pc_enable, 1);
    #2 reset_n = 1'b0;
    #1;
    exp_q.delete();
    check("rst_mv_en_off", pc_enable, 0);
    check("rst_mv_target", pc_target, 0);
    check("rst_mv_busy", busy, 0);
    check("rst_mv_count", queue_count, 0);
    check("rst_mv_ready", wp_ready, 1);
    check("rst_mv_state", dbg_state, S_IDLE);
    #10 reset_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/motion_sequencer.md
Name: motion_sequencer

Overview:
- Waypoint scheduler that sequences the position controller: buffers up to `depth` target positions with per-waypoint dwell times.
- Drives the controller's enable and target inputs, detects arrival from the encoder, holds position for the dwell, then issues the next waypoint.
- Supervises each move with a timeout and latches a fault on expiry.
- Sits between the host/command register block and the position controller.

Parameters:
- clk_freq_hz, 27_000_000, sys_clk frequency; ms tick period = clk_freq_hz/1000 cycles.
- counter_width, 32, width of encoder/target positions.
- depth, 4, waypoint queue entries (power of 2, >=2).
- dwell_width, 16, width of dwell time in ms.
- move_timeout_ms, 2000, max ms allowed in MOVE before fault.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- wp_valid  in  1  waypoint push request.
- wp_ready  out  1  queue can accept (count < depth).
- wp_position  in  counter_width  waypoint target position.
- wp_dwell_ms  in  dwell_width  hold time after arrival, ms.
- start  in  1  begin executing queue (level sampled in IDLE).
- abort  in  1  stop, flush queue, clear fault.
- encoder_position  in  counter_width  current encoder count.
- pc_enable  out  1  enable to position controller.
- pc_target  out  counter_width  target to position controller.
- busy  out  1  state is MOVE or DWELL.
- done  out  1  one-cycle pulse when the last waypoint's dwell completes.
- fault  out  1  move timeout latched.
- queue_count  out  $clog2(depth+1)  entries currently queued.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; queue empty; queue_count=0; wp_ready=1.
  - pc_enable=0, pc_target=0, busy=0, done=0, fault=0.
  - Counters cleared. Reset mid-move drops pc_enable immediately.
- Queue: FIFO with registered read/write pointers.
  - Push when wp_valid&wp_ready.
  - Pop only by the FSM.
  - Simultaneous push and pop allowed when not full; count unchanged.
  - wp_ready is combinational from count only.
- ms timebase: prescaler restarts to 0 on every state entry; ms_tick every clk_freq_hz/1000 cycles; ms counter increments on ms_tick.
- IDLE:
  - pc_enable=0.
  - start=1 & count>0 -> pop head: pc_target<=position, dwell_reg<=dwell, go MOVE (pc_enable=1 from next cycle).
  - start with empty queue is ignored, no done.
- MOVE:
  - pc_enable=1.
  - encoder_position==pc_target (exact compare, full width, wrap-aware by equality) -> DWELL.
  - ms counter reaching move_timeout_ms -> FAULT.
  - Arrival and timeout in the same cycle: arrival wins.
- DWELL:
  - pc_enable stays 1 so the controller holds/brakes.
  - Exits when ms counter == dwell_reg; dwell 0 exits after exactly 1 cycle.
  - On exit: count>0 -> pop next, MOVE. Else -> IDLE with done=1 for one cycle.
  - Encoder drift during dwell is ignored.
- FAULT:
  - fault=1, pc_enable=0, busy=0.
  - Queue retained; start ignored.
  - Only abort or reset leaves FAULT.
- abort: highest priority in every state. Next cycle: IDLE, queue flushed, pc_enable=0, fault=0, done=0. A push in the abort cycle is discarded.
- pc_target holds its last value outside MOVE/DWELL.
- Latency: start -> pc_enable high = 1 cycle; arrival -> state DWELL = 1 cycle.

Optional Feature:
- Macro: MOTION_SEQ_LOOP_EN.
- Defined:
  - Adds input port loop_mode (1 bit).
  - When loop_mode=1, every pop also re-pushes the same entry to the tail in the same cycle (count unchanged), so the sequence repeats until abort.
  - done is never pulsed.
  - wp_ready=0 while busy.
- Undefined: port absent; single pass, as described above.

Test Plan (clk_freq_hz=10_000, i.e. 10 cycles/ms; move_timeout_ms=5):
- Single move: push {100, 2ms}, start, encoder jumps to 100 after 7 cycles -> pc_enable=1 and pc_target=100 one cycle after start; DWELL 20 cycles; done pulse; pc_enable=0; queue_count=0.
- Full queue: push 4 entries -> wp_ready=0, queue_count=4; 5th push ignored. Run all 4 -> pc_target sequence matches push order; single done pulse.
- Timeout: push {500, 0}, start, encoder held at 0 -> after 50 cycles fault=1, pc_enable=0. start ignored. abort -> fault=0, queue_count=0.
- Abort mid-DWELL with 2 entries queued -> next cycle IDLE, pc_enable=0, queue_count=0, no done.
- Wrap and zero dwell: push {0xFFFFFFFF, 0} then {0x00000002, 0}; encoder 0xFFFFFFFF then 2 -> each DWELL lasts 1 cycle; done pulse.
- Reset asserted in MOVE -> all outputs return to reset values without a clock edge.
